// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard receiver: conditions PS2C/PS2D, frames 11-bit words, decodes E0/F0 prefixes into key events.
// Optional PS2_HOLD_MASK_EN builds a held-movement-key mask; otherwise hold_mask is tied to 0.
//
// state  | meaning
// IDLE   | waiting for a start bit (falling PS2C with PS2D low)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the odd-parity bit
// STOP   | checking parity and stop bit, then handing off the byte
module ps2_scan_receiver #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TO_WIDTH       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       PS2C,
  input  logic       PS2D,
  output logic       key_valid,
  output logic [7:0] scan_code,
  output logic       key_break,
  output logic       key_extended,
  output logic       parity_err,
  output logic       frame_err,
  output logic [7:0] hold_mask
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic                  ps2c_s1, ps2c_s2, ps2d_s1, ps2d_s2;
  logic [FILTER_LEN-1:0] filt_sr;
  logic                  ps2c_f, ps2c_f_d;
  logic                  strobe;

  state_t                state, state_nxt;
  logic [2:0]            bit_cnt;
  logic [7:0]            shift_q;
  logic                  par_q;
  logic [TO_WIDTH-1:0]   wd_cnt;
  logic                  timeout_hit, frame_chk;
  logic                  par_ok, par_fail, stop_fail, byte_good, is_prefix;
  logic                  ext_flag, brk_flag;

  // Synchronizers and filter idle high so reset never manufactures a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps2c_s1  <= 1'b1;
      ps2c_s2  <= 1'b1;
      ps2d_s1  <= 1'b1;
      ps2d_s2  <= 1'b1;
      filt_sr  <= '1;
      ps2c_f   <= 1'b1;
      ps2c_f_d <= 1'b1;
    end else begin
      ps2c_s1  <= PS2C;
      ps2c_s2  <= ps2c_s1;
      ps2d_s1  <= PS2D;
      ps2d_s2  <= ps2d_s1;
      filt_sr  <= {filt_sr[FILTER_LEN-2:0], ps2c_s2};
      if (&filt_sr)
        ps2c_f <= 1'b1;
      else if (~|filt_sr)
        ps2c_f <= 1'b0;
      ps2c_f_d <= ps2c_f;
    end
  end

  assign strobe = ps2c_f_d & ~ps2c_f;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    timeout_hit = 1'b0;
    frame_chk   = 1'b0;
    if (state != IDLE && !strobe && wd_cnt == TO_WIDTH'(TIMEOUT_CYCLES - 1)) begin
      timeout_hit = 1'b1;
      state_nxt   = IDLE;
    end else if (strobe) begin
      case (state)
        IDLE:    if (!ps2d_s2) state_nxt = DATA;
        DATA:    if (bit_cnt == 3'd7) state_nxt = PARITY;
        PARITY:  state_nxt = STOP;
        STOP: begin
          frame_chk = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign par_ok    = ^shift_q ^ par_q;
  assign par_fail  = frame_chk & ~par_ok;
  assign stop_fail = frame_chk & par_ok & ~ps2d_s2;
  assign byte_good = frame_chk & par_ok & ps2d_s2;
  assign is_prefix = (shift_q == 8'hE0) || (shift_q == 8'hF0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= 3'd0;
      shift_q <= 8'h00;
      par_q   <= 1'b0;
      wd_cnt  <= '0;
    end else begin
      if (state == IDLE || strobe)
        wd_cnt <= '0;
      else if (wd_cnt != '1)
        wd_cnt <= wd_cnt + TO_WIDTH'(1);
      if (strobe) begin
        case (state)
          IDLE:    bit_cnt <= 3'd0;
          DATA: begin
            shift_q <= {ps2d_s2, shift_q[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY:  par_q <= ps2d_s2;
          default: ;
        endcase
      end
    end
  end

  // Errors take priority and always drop any pending prefix.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_valid    <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      scan_code    <= 8'h00;
      key_break    <= 1'b0;
      key_extended <= 1'b0;
      ext_flag     <= 1'b0;
      brk_flag     <= 1'b0;
    end else begin
      key_valid  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (par_fail) begin
        parity_err <= 1'b1;
        ext_flag   <= 1'b0;
        brk_flag   <= 1'b0;
      end else if (stop_fail || timeout_hit) begin
        frame_err <= 1'b1;
        ext_flag  <= 1'b0;
        brk_flag  <= 1'b0;
      end else if (byte_good) begin
        if (shift_q == 8'hE0)
          ext_flag <= 1'b1;
        else if (shift_q == 8'hF0)
          brk_flag <= 1'b1;
        else begin
          key_valid    <= 1'b1;
          scan_code    <= shift_q;
          key_break    <= brk_flag;
          key_extended <= ext_flag;
          ext_flag     <= 1'b0;
          brk_flag     <= 1'b0;
        end
      end
    end
  end

`ifdef PS2_HOLD_MASK_EN
  logic [7:0] mask_q;
  logic [2:0] mask_idx;
  logic       mask_hit;

  always_comb begin
    mask_hit = 1'b1;
    mask_idx = 3'd0;
    case ({ext_flag, shift_q})
      {1'b0, 8'h1D}: mask_idx = 3'd0;
      {1'b0, 8'h1C}: mask_idx = 3'd1;
      {1'b0, 8'h1B}: mask_idx = 3'd2;
      {1'b0, 8'h23}: mask_idx = 3'd3;
      {1'b1, 8'h75}: mask_idx = 3'd4;
      {1'b1, 8'h6B}: mask_idx = 3'd5;
      {1'b1, 8'h72}: mask_idx = 3'd6;
      {1'b1, 8'h74}: mask_idx = 3'd7;
      default:       mask_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      mask_q <= 8'h00;
    else if (byte_good && !is_prefix && mask_hit && !par_fail)
      mask_q[mask_idx] <= ~brk_flag;
  end

  assign hold_mask = mask_q;
`else
  assign hold_mask = 8'h00;
`endif

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Bench for ps2_scan_receiver: directed scenarios plus randomized frames against a byte-level event model.
module tb_ps2_scan_receiver;
  localparam int FILTER_LEN     = 4;
  localparam int TIMEOUT_CYCLES = 300;
  localparam int TO_WIDTH       = 16;

  logic       clk = 1'b0;
  logic       rst, PS2C, PS2D;
  logic       key_valid, key_break, key_extended, parity_err, frame_err;
  logic [7:0] scan_code, hold_mask;

  always #5 clk = ~clk;

  ps2_scan_receiver #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TO_WIDTH(TO_WIDTH)) dut (
    .clk(clk), .rst(rst), .PS2C(PS2C), .PS2D(PS2D),
    .key_valid(key_valid), .scan_code(scan_code), .key_break(key_break),
    .key_extended(key_extended), .parity_err(parity_err), .frame_err(frame_err),
    .hold_mask(hold_mask)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int         kv_cnt = 0, pe_cnt = 0, fe_cnt = 0, overlap_cnt = 0;
  logic [7:0] ev_code = 8'h00;

  always @(negedge clk) begin
    if (key_valid) begin
      kv_cnt++;
      ev_code = scan_code;
    end
    if (parity_err) pe_cnt++;
    if (frame_err) fe_cnt++;
    if (int'(key_valid) + int'(parity_err) + int'(frame_err) > 1) overlap_cnt++;
  end

  // Reference model: keyboard-protocol meaning of each received byte.
  logic       m_ext, m_brk, m_kbrk, m_kext;
  logic [7:0] m_code, m_mask;
  int         e_kv, e_pe, e_fe;
  int         d_kv, d_pe, d_fe;
  logic [7:0] mv_code [8] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h75, 8'h6B, 8'h72, 8'h74};

  function automatic int mask_index(input logic [7:0] c, input logic e);
    for (int i = 0; i < 8; i++)
      if (mv_code[i] == c && ((i >= 4) == e)) return i;
    return -1;
  endfunction

  function automatic logic [7:0] exp_hold();
`ifdef PS2_HOLD_MASK_EN
    return m_mask;
`else
    return m_mask & 8'h00;
`endif
  endfunction

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_kbrk = 0; m_kext = 0; m_code = 8'h00; m_mask = 8'h00;
  endtask

  task automatic model_frame(input logic [7:0] b, input bit par_ok, input bit stop_ok);
    int idx;
    e_kv = 0; e_pe = 0; e_fe = 0;
    if (!par_ok) begin
      e_pe = 1; m_ext = 0; m_brk = 0;
    end else if (!stop_ok) begin
      e_fe = 1; m_ext = 0; m_brk = 0;
    end else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      e_kv = 1; m_code = b; m_kbrk = m_brk; m_kext = m_ext;
      idx = mask_index(b, m_ext);
      if (idx >= 0) m_mask[idx] = !m_brk;
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit stop_v, input int nbits);
    logic [10:0] bits;
    bits = {stop_v, (~^b) ^ flip_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk) PS2D = bits[i];
      repeat (10) @(negedge clk);
      PS2C = 1'b0;
      repeat (20) @(negedge clk);
      PS2C = 1'b1;
      repeat (10) @(negedge clk);
    end
    PS2D = 1'b1;
  endtask

  task automatic xfer(input logic [7:0] b, input bit flip_par, input bit stop_v);
    int kv0, pe0, fe0;
    kv0 = kv_cnt; pe0 = pe_cnt; fe0 = fe_cnt;
    send_frame(b, flip_par, stop_v, 11);
    repeat (20) @(negedge clk);
    d_kv = kv_cnt - kv0; d_pe = pe_cnt - pe0; d_fe = fe_cnt - fe0;
    model_frame(b, !flip_par, stop_v);
  endtask

  task automatic test_reset();
    rst = 1'b1; PS2C = 1'b1; PS2D = 1'b1;
    model_reset();
    repeat (5) @(negedge clk);
    n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_key_valid got %b want 0", key_valid); end
    n_checks++; if (scan_code !== 8'h00) begin n_fail++; $display("FAIL reset_scan_code got %h want 00", scan_code); end
    n_checks++; if (key_break !== 1'b0) begin n_fail++; $display("FAIL reset_key_break got %b want 0", key_break); end
    n_checks++; if (key_extended !== 1'b0) begin n_fail++; $display("FAIL reset_key_extended got %b want 0", key_extended); end
    n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_parity_err got %b want 0", parity_err); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    n_checks++; if (hold_mask !== 8'h00) begin n_fail++; $display("FAIL reset_hold_mask got %h want 00", hold_mask); end
    rst = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_make_key();
    xfer(8'h1D, 0, 1);
    n_checks++; if (d_kv !== 1) begin n_fail++; $display("FAIL make_1d_pulses got %0d want 1", d_kv); end
    n_checks++; if (scan_code !== 8'h1D) begin n_fail++; $display("FAIL make_1d_code got %h want 1d", scan_code); end
    n_checks++; if (key_break !== 1'b0 || key_extended !== 1'b0) begin n_fail++; $display("FAIL make_1d_flags got brk=%b ext=%b want 0 0", key_break, key_extended); end
    n_checks++; if (hold_mask !== exp_hold()) begin n_fail++; $display("FAIL make_1d_mask got %h want %h", hold_mask, exp_hold()); end
  endtask

  task automatic test_ext_release();
    int kv_pre;
    xfer(8'hE0, 0, 1); kv_pre = d_kv;
    xfer(8'h74, 0, 1);
    n_checks++; if (kv_pre !== 0 || d_kv !== 1) begin n_fail++; $display("FAIL ext_make_pulses got %0d/%0d want 0/1", kv_pre, d_kv); end
    n_checks++; if (key_extended !== 1'b1 || key_break !== 1'b0) begin n_fail++; $display("FAIL ext_make_flags got ext=%b brk=%b want 1 0", key_extended, key_break); end
    n_checks++; if (hold_mask !== exp_hold()) begin n_fail++; $display("FAIL ext_make_mask got %h want %h", hold_mask, exp_hold()); end
    xfer(8'hE0, 0, 1); kv_pre = d_kv;
    xfer(8'hF0, 0, 1); kv_pre += d_kv;
    xfer(8'h74, 0, 1);
    n_checks++; if (kv_pre !== 0 || d_kv !== 1) begin n_fail++; $display("FAIL ext_release_pulses got %0d/%0d want 0/1", kv_pre, d_kv); end
    n_checks++; if (ev_code !== 8'h74 || key_break !== 1'b1 || key_extended !== 1'b1) begin n_fail++; $display("FAIL ext_release_event got code=%h brk=%b ext=%b want 74 1 1", ev_code, key_break, key_extended); end
    n_checks++; if (hold_mask !== exp_hold()) begin n_fail++; $display("FAIL ext_release_mask got %h want %h", hold_mask, exp_hold()); end
  endtask

  task automatic test_parity_err();
    xfer(8'h23, 1, 1);
    n_checks++; if (d_pe !== 1 || d_kv !== 0 || d_fe !== 0) begin n_fail++; $display("FAIL parity_pulses got pe=%0d kv=%0d fe=%0d want 1 0 0", d_pe, d_kv, d_fe); end
    n_checks++; if (scan_code !== 8'h74) begin n_fail++; $display("FAIL parity_code_held got %h want 74", scan_code); end
  endtask

  task automatic test_frame_err();
    xfer(8'h1C, 0, 0);
    n_checks++; if (d_fe !== 1 || d_kv !== 0 || d_pe !== 0) begin n_fail++; $display("FAIL stop_bit_pulses got fe=%0d kv=%0d pe=%0d want 1 0 0", d_fe, d_kv, d_pe); end
    xfer(8'hF0, 0, 1);
    xfer(8'($urandom), 1, 1);
    n_checks++; if (d_pe !== 1) begin n_fail++; $display("FAIL prefix_then_parity got pe=%0d want 1", d_pe); end
    xfer(8'h1C, 0, 1);
    n_checks++; if (d_kv !== 1 || scan_code !== 8'h1C || key_break !== 1'b0) begin n_fail++; $display("FAIL flag_cleared got kv=%0d code=%h brk=%b want 1 1c 0", d_kv, scan_code, key_break); end
  endtask

  task automatic test_timeout();
    int kv0, fe0, pe0;
    kv0 = kv_cnt; fe0 = fe_cnt; pe0 = pe_cnt;
    send_frame(8'h55, 0, 1, 5);
    repeat (TIMEOUT_CYCLES - 80) @(negedge clk);
    n_checks++; if (fe_cnt - fe0 !== 0) begin n_fail++; $display("FAIL timeout_early got fe=%0d want 0", fe_cnt - fe0); end
    repeat (100) @(negedge clk);
    n_checks++; if (fe_cnt - fe0 !== 1 || kv_cnt - kv0 !== 0 || pe_cnt - pe0 !== 0) begin n_fail++; $display("FAIL timeout_abort got fe=%0d kv=%0d pe=%0d want 1 0 0", fe_cnt - fe0, kv_cnt - kv0, pe_cnt - pe0); end
    m_ext = 0; m_brk = 0;
    xfer(8'h1B, 0, 1);
    n_checks++; if (d_kv !== 1 || scan_code !== 8'h1B || key_break !== 1'b0 || key_extended !== 1'b0) begin n_fail++; $display("FAIL after_timeout got kv=%0d code=%h brk=%b ext=%b want 1 1b 0 0", d_kv, scan_code, key_break, key_extended); end
    n_checks++; if (hold_mask !== exp_hold()) begin n_fail++; $display("FAIL after_timeout_mask got %h want %h", hold_mask, exp_hold()); end
  endtask

  task automatic test_reset_glitch();
    int kv0, fe0, pe0;
    send_frame(8'h1C, 0, 1, 4);
    @(negedge clk) rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    n_checks++; if (scan_code !== 8'h00 || key_break !== 1'b0 || key_extended !== 1'b0 || hold_mask !== 8'h00) begin n_fail++; $display("FAIL midframe_reset got code=%h brk=%b ext=%b mask=%h want 00 0 0 00", scan_code, key_break, key_extended, hold_mask); end
    kv0 = kv_cnt; fe0 = fe_cnt; pe0 = pe_cnt;
    PS2D = 1'b0;
    for (int g = 0; g < 5; g++) begin
      @(negedge clk) PS2C = 1'b0;
      repeat (2) @(negedge clk);
      PS2C = 1'b1;
      repeat (15) @(negedge clk);
    end
    PS2D = 1'b1;
    repeat (20) @(negedge clk);
    xfer(8'h1D, 0, 1);
    n_checks++; if (kv_cnt - kv0 !== 1 || fe_cnt - fe0 !== 0 || pe_cnt - pe0 !== 0) begin n_fail++; $display("FAIL glitch_events got kv=%0d fe=%0d pe=%0d want 1 0 0", kv_cnt - kv0, fe_cnt - fe0, pe_cnt - pe0); end
    n_checks++; if (scan_code !== 8'h1D || key_break !== 1'b0 || key_extended !== 1'b0) begin n_fail++; $display("FAIL glitch_decode got code=%h brk=%b ext=%b want 1d 0 0", scan_code, key_break, key_extended); end
    n_checks++; if (hold_mask !== exp_hold()) begin n_fail++; $display("FAIL glitch_mask got %h want %h", hold_mask, exp_hold()); end
  endtask

  task automatic test_random();
    logic [7:0] b;
    bit         flip, stp;
    int         r;
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      flip = 0; stp = 1;
      case (r)
        0:       b = 8'hE0;
        1:       b = 8'hF0;
        2: begin b = 8'($urandom); flip = 1; end
        3: begin b = 8'($urandom); stp = 0; end
        4, 5, 6: b = mv_code[$urandom_range(0, 7)];
        default: b = 8'($urandom);
      endcase
      xfer(b, flip, stp);
      n_checks++; if (d_kv !== e_kv || d_pe !== e_pe || d_fe !== e_fe) begin n_fail++; $display("FAIL rand_pulses byte=%h got kv=%0d pe=%0d fe=%0d want %0d %0d %0d", b, d_kv, d_pe, d_fe, e_kv, e_pe, e_fe); end
      n_checks++; if (scan_code !== m_code || key_break !== m_kbrk || key_extended !== m_kext) begin n_fail++; $display("FAIL rand_event byte=%h got code=%h brk=%b ext=%b want %h %b %b", b, scan_code, key_break, key_extended, m_code, m_kbrk, m_kext); end
      n_checks++; if (hold_mask !== exp_hold()) begin n_fail++; $display("FAIL rand_mask byte=%h got %h want %h", b, hold_mask, exp_hold()); end
    end
  endtask

  initial begin
    test_reset();
    test_make_key();
    test_ext_release();
    test_parity_err();
    test_frame_err();
    test_timeout();
    test_reset_glitch();
    test_random();
    n_checks++; if (overlap_cnt !== 0) begin n_fail++; $display("FAIL pulse_exclusive got %0d overlapping cycles want 0", overlap_cnt); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
